// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and a ceil-log2 helper for
// instantiators sizing ADDR_W from a required depth.
package fifo_pkg;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Streaming FIFO port bundle: master drives requests/data, slave is the FIFO.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              we;
  logic              re;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic [ADDR_W:0]   count;
  logic              almost_full;
  logic              full;
  logic              almost_empty;
  logic              empty;
  logic              over;
  logic              under;

  modport master (
    output we, re, din,
    input  dout, valid, count, almost_full, full, almost_empty, empty, over, under
  );

  modport slave (
    input  we, re, din,
    output dout, valid, count, almost_full, full, almost_empty, empty, over, under
  );
endinterface

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
// The array is never reset; only the read register clears.
module fifo_sync_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard (registered) or FWFT read,
// fill level, programmable almost flags and over/under error pulses.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned AF_LEVEL = (2**ADDR_W) - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned MODE     = MODE_STD
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic            FWFT    = (MODE == MODE_FWFT);

  logic [ADDR_W:0]   wr_ptr, rd_ptr, count_q, count_next;
  logic              empty_q, full_q, af_q, ae_q, valid_q, over_q, under_q;
  logic              ra, wa, fetch, ram_re, valid_next;
  logic [DATA_W-1:0] rdata;

  assign ra = bus.re & ~empty_q;
  assign wa = bus.we & (~full_q | ra);

  // FWFT keeps the head word in the RAM read register; the RAM is read ahead
  // whenever it holds unfetched words and the head slot is free or being consumed.
  assign fetch  = (wr_ptr != rd_ptr) & (~valid_q | ra);
  assign ram_re = rst_n & (FWFT ? fetch : ra);

  always_comb begin
    count_next = count_q;
    case ({wa, ra})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
    valid_next = FWFT ? (fetch | (valid_q & ~ra)) : ra;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      if (wa)     wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      empty_q <= FWFT ? ~valid_next : (count_next == '0);
      full_q  <= (count_next == DEPTH_C);
      af_q    <= (count_next >= AF_C);
      ae_q    <= (count_next <= AE_C);
      valid_q <= valid_next;
      over_q  <= bus.we & ~wa;
      under_q <= bus.re & ~ra;
    end
  end

  fifo_sync_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wa & rst_n),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.din),
    .re    (ram_re),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign bus.dout         = rdata;
  assign bus.valid        = valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.over         = over_q;
  assign bus.under        = under_q;
endmodule
